// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer: FSM states, widths,
// default reset PC / halt sentinel and the beq offset helper.
package fetch_pkg;

  localparam int PC_W    = 30;
  localparam int INSTR_W = 32;

  localparam logic [PC_W-1:0]    RESET_PC_DEF  = '0;
  localparam logic [INSTR_W-1:0] HALT_WORD_DEF = 32'hffff_ffff;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    IDLE = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } fetch_state_e;

  // beq immediate is a signed word offset relative to pc + 1
  function automatic logic [PC_W-1:0] branch_off(input logic [INSTR_W-1:0] instr);
    return {{(PC_W-16){instr[15]}}, instr[15:0]};
  endfunction

endpackage

// File: rtl/fetch_seq_imem_ram.sv
// Instruction memory: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset so a program survives a core reset.
module imem_ram #(
  parameter int DEPTH_LOG2 = 5,
  parameter int WIDTH      = 32
) (
  input  logic                  Clk,
  input  logic                  wr_en,
  input  logic [DEPTH_LOG2-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [DEPTH_LOG2-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge Clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: loads a program image over valid/ready, then walks the
// word PC each cycle (sequential or beq-taken) until the halt sentinel.
module fetch_seq
  import fetch_pkg::*;
#(
  parameter int                 DEPTH_LOG2 = 5,
  parameter logic [PC_W-1:0]    RESET_PC   = RESET_PC_DEF,
  parameter logic [INSTR_W-1:0] HALT_WORD  = HALT_WORD_DEF
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [INSTR_W-1:0]    ld_data,
  input  logic                  ld_last,
  input  logic                  run,
  input  logic                  IfBeq,
  input  logic                  Zero,
  input  logic                  stall,
  output logic [INSTR_W-1:0]    Instr,
  output logic                  instr_valid,
  output logic [PC_W-1:0]       pc,
  output logic                  halted
);

  fetch_state_e          state_reg, state_next;
  logic [PC_W-1:0]       pc_reg, pc_next;
  logic                  ld_fire;

  assign ld_fire = ld_valid & ld_ready;
  assign pc      = pc_reg;

  imem_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (INSTR_W)
  ) u_imem (
    .Clk     (Clk),
    .wr_en   (ld_fire),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_addr (pc_reg[DEPTH_LOG2-1:0]),
    .rd_data (Instr)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= LOAD;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    case (state_reg)
      LOAD: begin
        if (ld_fire && ld_last) begin
          state_next = IDLE;
          pc_next    = RESET_PC;
        end
      end
      IDLE, HALT: begin
        // A loader beat always beats run; HALT only leaves via a reload
        if (ld_fire) begin
          state_next = ld_last ? IDLE : LOAD;
          if (ld_last) pc_next = RESET_PC;
        end else if (run && state_reg == IDLE) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (!stall) begin
          if (Instr == HALT_WORD) begin
            state_next = HALT;
          end else begin
            pc_next = pc_reg + PC_W'(1) + ((IfBeq && Zero) ? branch_off(Instr) : '0);
          end
        end
      end
      default: state_next = LOAD;
    endcase
  end

  always_comb begin
    ld_ready    = 1'b1;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_reg)
      RUN: begin
        ld_ready    = 1'b0;
        instr_valid = 1'b1;
      end
      HALT:    halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: load, run, branch, aliasing, stall, halt,
// loader blocking in RUN and reset retention of memory.
module tb_fetch_seq;

  logic        Clk;
  logic        Reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        run;
  logic        IfBeq;
  logic        Zero;
  logic        stall;
  logic [31:0] Instr;
  logic        instr_valid;
  logic [29:0] pc;
  logic        halted;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] HW = 32'hffff_ffff;

  fetch_seq dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .run         (run),
    .IfBeq       (IfBeq),
    .Zero        (Zero),
    .stall       (stall),
    .Instr       (Instr),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halted      (halted)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic load(input logic [4:0] a, input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    ld_last  = last;
    cyc();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic run_pulse();
    run = 1'b1;
    cyc();
    run = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; ld_valid = 0; ld_addr = '0; ld_data = '0; ld_last = 0;
    run = 0; IfBeq = 0; Zero = 0; stall = 0;
    #1 Reset = 1'b0;
    #2;
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    cyc(); cyc();
    Reset = 1'b1;

    // Program A: two ALU ops then halt
    load(5'd0, 32'h00228021, 1'b0);
    load(5'd1, 32'h00228823, 1'b0);
    chk("load_valid_low", 32'(instr_valid), 32'd0);
    load(5'd2, HW, 1'b1);
    chk("idle_ready", 32'(ld_ready), 32'd1);
    chk("idle_pc", 32'(pc), 32'd0);
    chk("idle_instr", Instr, 32'h00228021);
    run_pulse();
    chk("run0_valid", 32'(instr_valid), 32'd1);
    chk("run0_ready", 32'(ld_ready), 32'd0);
    chk("run0_pc", 32'(pc), 32'd0);
    chk("run0_instr", Instr, 32'h00228021);
    cyc();
    chk("run1_pc", 32'(pc), 32'd1);
    chk("run1_instr", Instr, 32'h00228823);
    cyc();
    chk("run2_pc", 32'(pc), 32'd2);
    chk("run2_instr", Instr, HW);
    chk("run2_halted", 32'(halted), 32'd0);
    cyc();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(pc), 32'd2);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    run_pulse();
    chk("halt_run_ignored", 32'(halted), 32'd1);

    // Program B: reload from HALT
    load(5'd2, 32'h0, 1'b0);
    chk("reload_halted", 32'(halted), 32'd0);
    chk("reload_pc_held", 32'(pc), 32'd2);
    load(5'd3, 32'h0, 1'b0);
    load(5'd4, 32'h0, 1'b0);
    load(5'd5, 32'h0, 1'b0);
    load(5'd6, 32'h10210004, 1'b0);
    load(5'd7, 32'h0, 1'b0);
    load(5'd8, 32'h1042ffe0, 1'b0);
    load(5'd9, HW, 1'b0);
    load(5'd11, HW, 1'b1);
    chk("progB_pc", 32'(pc), 32'd0);
    // run with a loader beat in IDLE: load wins
    run = 1'b1;
    load(5'd10, 32'h0, 1'b0);
    chk("idle_runld_valid", 32'(instr_valid), 32'd0);
    cyc();
    run = 1'b0;
    chk("load_run_ignored", 32'(instr_valid), 32'd0);
    load(5'd10, 32'h0, 1'b1);
    run_pulse();
    chk("progB_run0", 32'(instr_valid), 32'd1);
    // loader attempt during RUN must not write
    ld_valid = 1'b1; ld_addr = 5'd0; ld_data = 32'h0;
    #1;
    chk("run_ld_ready", 32'(ld_ready), 32'd0);
    cyc();
    ld_valid = 1'b0;
    chk("progB_pc1", 32'(pc), 32'd1);
    cyc(); cyc();
    chk("progB_pc3", 32'(pc), 32'd3);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", 32'(pc), 32'd3);
      chk("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    cyc(); cyc(); cyc();
    chk("beq_pc6", 32'(pc), 32'd6);
    chk("beq_instr6", Instr, 32'h10210004);
    IfBeq = 1'b1; Zero = 1'b0;
    cyc();
    chk("beq_not_taken", 32'(pc), 32'd7);
    IfBeq = 1'b0;
    cyc();
    chk("beq_pc8", 32'(pc), 32'd8);
    IfBeq = 1'b1; Zero = 1'b1;
    cyc();
    chk("beq_neg_pc", 32'(pc), 32'h3fffffe9);
    chk("alias_instr", Instr, HW);
    // halt word with branch asserted: stall first, then halt without branching
    stall = 1'b1;
    cyc(); cyc();
    chk("stall_halt_pc", 32'(pc), 32'h3fffffe9);
    chk("stall_no_halt", 32'(halted), 32'd0);
    stall = 1'b0;
    cyc();
    chk("halt_after_stall", 32'(halted), 32'd1);
    chk("halt_over_branch", 32'(pc), 32'h3fffffe9);
    IfBeq = 1'b0; Zero = 1'b0;

    // Reset mid-RUN, memory retained
    load(5'd12, 32'h0, 1'b1);
    run_pulse();
    chk("m0_retained", Instr, 32'h00228021);
    for (int i = 0; i < 5; i++) cyc();
    chk("pre_reset_pc5", 32'(pc), 32'd5);
    Reset = 1'b0;
    #1;
    chk("midrun_reset_pc", 32'(pc), 32'd0);
    chk("midrun_reset_valid", 32'(instr_valid), 32'd0);
    chk("midrun_reset_ready", 32'(ld_ready), 32'd1);
    cyc();
    Reset = 1'b1;
    load(5'd12, 32'h0, 1'b1);
    run_pulse();
    chk("rerun_instr0", Instr, 32'h00228021);
    for (int i = 0; i < 6; i++) cyc();
    chk("rerun_pc6", 32'(pc), 32'd6);
    IfBeq = 1'b1; Zero = 1'b1;
    cyc();
    chk("beq_taken_pc", 32'(pc), 32'd11);
    chk("beq_taken_instr", Instr, HW);
    IfBeq = 1'b0; Zero = 1'b0;
    cyc();
    chk("final_halt", 32'(halted), 32'd1);
    chk("final_pc", 32'(pc), 32'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Fetch sequencer for the single-cycle MIPS core. It owns the 32-word instruction memory and the word program counter. Before execution it accepts a program image through a valid/ready loader port. It then sequences fetch every cycle, applying the beq decision from the datapath, and stops on a halt sentinel. The core reads `Instr` from it; a testbench or boot host drives the loader.

## Interface
- `DEPTH_LOG2`, default 5: log2 of instruction memory words (32).
- `RESET_PC`, default 30'h0: word address loaded into `pc` on reset and on load completion.
- `HALT_WORD`, default 32'hffffffff: instruction that ends execution.

Ports:
- `Clk` in 1: single clock, all state on rising edge.
- `Reset` in 1: asynchronous, active-low.
- `ld_valid` in 1: loader word present.
- `ld_ready` out 1: sequencer accepts loader words.
- `ld_addr` in DEPTH_LOG2: word index to write.
- `ld_data` in 32: instruction word.
- `ld_last` in 1: final word of image; qualified by handshake.
- `run` in 1: start execution from IDLE.
- `IfBeq` in 1: current instruction is beq.
- `Zero` in 1: ALU equality result.
- `stall` in 1: hold current instruction this cycle.
- `Instr` out 32: M[pc[DEPTH_LOG2-1:0]].
- `instr_valid` out 1: high in RUN only.
- `pc` out 30: word program counter.
- `halted` out 1: high in HALT.

## Operation
- States: LOAD, IDLE, RUN, HALT. Reset enters LOAD.
- LOAD:
  - `ld_ready`=1.
  - On `ld_valid&ld_ready`: M[ld_addr] <= ld_data.
  - If `ld_last` on that same beat: go to IDLE, `pc` <= RESET_PC.
- IDLE:
  - `ld_ready`=1.
  - An accepted word is written and moves the block to LOAD, or stays in IDLE if `ld_last`.
  - `run` with no `ld_valid`: go to RUN.
  - `run` together with `ld_valid`: the load wins and `run` is ignored.
- RUN:
  - `ld_ready`=0; `ld_valid` is ignored and the memory is unchanged.
  - If `stall`=1: `pc` holds.
  - Else if `Instr`==HALT_WORD: go to HALT and `pc` holds.
  - Else `pc` <= pc + 1 + off, where off = (IfBeq&Zero) ? sign-extend(Instr[15:0]) to 30 bits : 0.
  - Arithmetic is 30-bit modulo 2^30 and wraps silently. The memory index is `pc[DEPTH_LOG2-1:0]`, so it aliases modulo 32.
- HALT:
  - `ld_ready`=1.
  - An accepted word behaves as in IDLE, so the memory can be reloaded for another run.
  - `run` is ignored.
- Halt has priority over the branch: HALT_WORD is never executed as a branch.
- Memory contents are not reset. They persist across `Reset` and are X until written.

## Timing
- `Reset` low, asynchronously:
  - state=LOAD, `pc`=RESET_PC.
  - `instr_valid`=0, `halted`=0, `ld_ready`=1 (combinational from state).
- `Instr` is combinational from `pc` and memory, with zero latency.
- A loader write on edge N is readable via `Instr` after edge N.
- `pc` update takes effect on the edge where the RUN conditions are sampled. The next instruction appears the same cycle after that edge.
- `instr_valid` and `halted` are decoded from registered state, so they carry no combinational path from inputs.
- RUN is entered one edge after `run` is sampled. The first valid instruction is M[RESET_PC] in that cycle.
- A write to the address currently addressed by `pc` in IDLE/LOAD changes `Instr` immediately. This is legal.
- Reset asserted mid-RUN aborts at once, with no partial `pc` update, and returns to LOAD.

## Structure
- Package `fetch_pkg`:
  - state enum {LOAD, IDLE, RUN, HALT}.
  - HALT_WORD and RESET_PC default constants.
  - Width localparams: PC_W=30, INSTR_W=32.
- Sub-module `imem_ram`: 2^DEPTH_LOG2 x 32, one synchronous write port and one asynchronous read port, no reset.
- `fetch_seq` holds the FSM, the `pc` register, the branch adder and the loader handshake.

## Test plan
- Load M[0]=32'h00228021, M[1]=32'h00228823, M[2]=HALT_WORD with `ld_last` on the third beat -> IDLE, `pc`=0, `ld_ready`=1. Pulse `run` -> Instr sequence 00228021, 00228823, ffffffff at pc 0,1,2. `halted`=1 the next cycle, with `pc`=2 held.
- M[6]=32'h10210004, IfBeq=Zero=1 at pc 6 -> next pc=11. IfBeq=1, Zero=0 -> next pc=7.
- M[8]=32'h1042ffe0, taken at pc 8 -> pc=30'h3fffffe9, Instr=M[9] (index aliasing).
- `stall`=1 for 3 cycles at pc 3 -> pc stays 3 and `instr_valid` stays 1. A HALT_WORD at a stalled pc does not halt until `stall` drops.
- In RUN, drive `ld_valid`=1, ld_addr=0, ld_data=0 -> `ld_ready`=0 and M[0] unchanged. In IDLE, `run` and `ld_valid` together -> write accepted, state LOAD, no RUN.
- `Reset` low mid-RUN at pc 5 -> immediately LOAD, pc=0, `instr_valid`=0. Memory is retained: `run` after `ld_last` re-executes the same program.
